// File: rtl/cavlc_pkg.sv
// Shared definitions for the CAVLC bitstream front end: default widths and the
// per-cycle command of the bitstream window.
package cavlc_pkg;

   localparam int unsigned BS_IN_W  = 16;
   localparam int unsigned BS_WIN_W = 16;
   localparam int unsigned BS_CNT_W = 32;

   // Per-cycle window command, listed in decreasing priority.
   typedef enum logic [1:0] {
      BS_NONE,
      BS_FLUSH,
      BS_SHIFT,
      BS_ALIGN
   } bs_cmd_e;

   // Resolve the control strobes into one command; a disabled block does nothing.
   function automatic bs_cmd_e bs_decode(input logic enable, input logic flush,
                                         input logic shiftEn, input logic byteAlign);
      bs_cmd_e cmd;
      cmd = BS_NONE;
      if (enable) begin
         if (flush) begin
            cmd = BS_FLUSH;
         end else if (shiftEn) begin
            cmd = BS_SHIFT;
         end else if (byteAlign) begin
            cmd = BS_ALIGN;
         end
      end
      return cmd;
   endfunction

endpackage

// File: rtl/bs_funnel.sv
// Combinational funnel for the bitstream window: drops consumed bits off the
// top of the buffer and merges a new word directly behind the surviving bits.
module bs_funnel
   import cavlc_pkg::*;
#(
   parameter int unsigned BUF_W = 32,
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OFF_W = 6
) (
   input  logic [BUF_W-1:0] bufIn,
   input  logic [OFF_W-1:0] shiftAmt,
   input  logic [OFF_W-1:0] insPos,
   input  logic             insEn,
   input  logic [IN_W-1:0]  word,
   output logic [BUF_W-1:0] bufOut
);

   logic [BUF_W-1:0] shifted;
   logic [BUF_W-1:0] inserted;

   // Left-shift out consumed bits, then OR the left-justified word in at insPos.
   always_comb begin
      shifted  = bufIn << shiftAmt;
      inserted = '0;
      if (insEn) begin
         inserted = {word, {(BUF_W-IN_W){1'b0}}} >> insPos;
      end
      bufOut = shifted | inserted;
   end

endmodule

// File: rtl/bitstream_window.sv
// Bitstream look-ahead window: buffers upstream words and presents the next
// WIN_W unconsumed bits MSB first, with shift, byte-align and flush commands.
module bitstream_window
   import cavlc_pkg::*;
#(
   parameter int unsigned IN_W    = BS_IN_W,
   parameter int unsigned WIN_W   = BS_WIN_W,
   parameter int unsigned CNT_W   = BS_CNT_W,
   localparam int unsigned BUF_W   = WIN_W + IN_W,
   localparam int unsigned FILL_W  = $clog2(BUF_W + 1),
   localparam int unsigned SHIFT_W = $clog2(WIN_W + 1)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Enable,
   input  logic [IN_W-1:0]    InData,
   input  logic               InValid,
   output logic               InReady,
   output logic [WIN_W-1:0]   Window,
   output logic               WindowValid,
   output logic [FILL_W-1:0]  Fill,
   input  logic               ShiftEn,
   input  logic [SHIFT_W-1:0] NumShift,
   input  logic               ByteAlign,
   input  logic               Flush,
   output logic [CNT_W-1:0]   BitCount,
   output logic               ShiftErr
);

   localparam logic [FILL_W-1:0]  ACCEPT_MAX = FILL_W'(BUF_W - IN_W);
   localparam logic [SHIFT_W-1:0] SHIFT_MAX  = SHIFT_W'(WIN_W);

   logic [BUF_W-1:0]  bufQ, bufD, funnelOut;
   logic [FILL_W-1:0] fillQ, fillD;
   logic [FILL_W-1:0] consumed, remaining;
   logic [CNT_W-1:0]  bitCountQ, bitCountD;
   logic              shiftErrQ, shiftErrD;
   logic              accept, shiftOk, alignOk;
   logic [2:0]        alignDist;
   bs_cmd_e           cmd;

   // Ready depends only on state and the enable/reset/flush qualifiers, never on the
   // consume request, so upstream sees no path from the decoders.
   always_comb begin
      InReady = Enable & ~Reset & ~Flush & (fillQ <= ACCEPT_MAX);
      accept  = InValid & InReady;
   end

   // Command decode, legality checks and next-state computation.
   always_comb begin
      cmd       = bs_decode(Enable, Flush, ShiftEn, ByteAlign);
      alignDist = 3'(4'd8 - 4'(bitCountQ[2:0]));
      shiftOk   = (NumShift <= SHIFT_MAX) && (FILL_W'(NumShift) <= fillQ);
      alignOk   = FILL_W'(alignDist) <= fillQ;
      consumed  = '0;
      shiftErrD = shiftErrQ;
      unique case (cmd)
         BS_SHIFT: begin
            if (shiftOk) begin
               consumed = FILL_W'(NumShift);
            end else begin
               shiftErrD = 1'b1;
            end
         end
         BS_ALIGN: begin
            if (alignOk) begin
               consumed = FILL_W'(alignDist);
            end else begin
               shiftErrD = 1'b1;
            end
         end
         BS_FLUSH, BS_NONE: ;
         default: ;
      endcase
      remaining = fillQ - consumed;
      bufD      = funnelOut;
      fillD     = remaining + (accept ? FILL_W'(IN_W) : '0);
      bitCountD = bitCountQ + CNT_W'(consumed);
      if (cmd == BS_FLUSH) begin
         bufD  = '0;
         fillD = '0;
      end
   end

   bs_funnel #(
      .BUF_W (BUF_W),
      .IN_W  (IN_W),
      .OFF_W (FILL_W)
   ) uFunnel (
      .bufIn    (bufQ),
      .shiftAmt (consumed),
      .insPos   (remaining),
      .insEn    (accept),
      .word     (InData),
      .bufOut   (funnelOut)
   );

   // State registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bufQ      <= '0;
         fillQ     <= '0;
         bitCountQ <= '0;
         shiftErrQ <= 1'b0;
      end else begin
         bufQ      <= bufD;
         fillQ     <= fillD;
         bitCountQ <= bitCountD;
         shiftErrQ <= shiftErrD;
      end
   end

   // Outputs straight from state.
   always_comb begin
      Window      = bufQ[BUF_W-1 -: WIN_W];
      WindowValid = fillQ >= FILL_W'(WIN_W);
      Fill        = fillQ;
      BitCount    = bitCountQ;
      ShiftErr    = shiftErrQ;
   end

endmodule

// File: tb/tb_bitstream_window.sv
// Directed bench for bitstream_window: default 16/16 instance plus an 8/32
// instance with a 4-bit counter to exercise width parameters and wrap.
module tb_bitstream_window;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en;

   // Instance A: IN_W=16, WIN_W=16, CNT_W=32
   logic [15:0] aData;
   logic        aValid, aShift, aAlign, aFlush;
   logic [4:0]  aNum;
   logic        aReady, aWinV, aErr;
   logic [15:0] aWin;
   logic [5:0]  aFill;
   logic [31:0] aCnt;

   // Instance B: IN_W=8, WIN_W=32, CNT_W=4
   logic [7:0]  bData;
   logic        bValid, bShift, bAlign, bFlush;
   logic [5:0]  bNum;
   logic        bReady, bWinV, bErr;
   logic [31:0] bWin;
   logic [5:0]  bFill;
   logic [3:0]  bCnt;

   int total = 0;
   int bad   = 0;

   bitstream_window #(
      .IN_W  (16),
      .WIN_W (16),
      .CNT_W (32)
   ) dutA (
      .Clk         (clk),
      .Reset       (rst),
      .Enable      (en),
      .InData      (aData),
      .InValid     (aValid),
      .InReady     (aReady),
      .Window      (aWin),
      .WindowValid (aWinV),
      .Fill        (aFill),
      .ShiftEn     (aShift),
      .NumShift    (aNum),
      .ByteAlign   (aAlign),
      .Flush       (aFlush),
      .BitCount    (aCnt),
      .ShiftErr    (aErr)
   );

   bitstream_window #(
      .IN_W  (8),
      .WIN_W (32),
      .CNT_W (4)
   ) dutB (
      .Clk         (clk),
      .Reset       (rst),
      .Enable      (en),
      .InData      (bData),
      .InValid     (bValid),
      .InReady     (bReady),
      .Window      (bWin),
      .WindowValid (bWinV),
      .Fill        (bFill),
      .ShiftEn     (bShift),
      .NumShift    (bNum),
      .ByteAlign   (bAlign),
      .Flush       (bFlush),
      .BitCount    (bCnt),
      .ShiftErr    (bErr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1;
      aData = '0; aValid = 0; aShift = 0; aNum = '0; aAlign = 0; aFlush = 0;
      bData = '0; bValid = 0; bShift = 0; bNum = '0; bAlign = 0; bFlush = 0;
      tick(); tick();
      chk("rst_fill", 64'(aFill), 64'd0);
      chk("rst_win", 64'(aWin), 64'h0);
      chk("rst_winv", 64'(aWinV), 64'd0);
      chk("rst_cnt", 64'(aCnt), 64'd0);
      chk("rst_err", 64'(aErr), 64'd0);
      chk("rst_ready", 64'(aReady), 64'd0);
      rst = 1'b0; #1;
      chk("idle_ready", 64'(aReady), 64'd1);

      // T1 fill
      aValid = 1; aData = 16'hA5C3; tick();
      aData = 16'h1234; tick();
      aValid = 0; #1;
      chk("t1_fill", 64'(aFill), 64'd32);
      chk("t1_win", 64'(aWin), 64'hA5C3);
      chk("t1_winv", 64'(aWinV), 64'd1);
      chk("t1_ready", 64'(aReady), 64'd0);

      // T2 shift
      aShift = 1; aNum = 5'd4; tick(); aShift = 0;
      chk("t2a_win", 64'(aWin), 64'h5C31);
      chk("t2a_fill", 64'(aFill), 64'd28);
      chk("t2a_cnt", 64'(aCnt), 64'd4);
      aShift = 1; aNum = 5'd16; tick(); aShift = 0;
      chk("t2b_win", 64'(aWin), 64'h2340);
      chk("t2b_fill", 64'(aFill), 64'd12);
      chk("t2b_winv", 64'(aWinV), 64'd0);
      chk("t2b_cnt", 64'(aCnt), 64'd20);

      // T3 append behind remaining bits, then shift+append in one cycle
      aShift = 1; aNum = 5'd4; tick(); aShift = 0;
      chk("t3a_fill", 64'(aFill), 64'd8);
      chk("t3a_win", 64'(aWin), 64'h3400);
      aValid = 1; aData = 16'hBEEF; tick(); aValid = 0; #1;
      chk("t3b_fill", 64'(aFill), 64'd24);
      chk("t3b_win", 64'(aWin), 64'h34BE);
      chk("t3b_ready", 64'(aReady), 64'd0);
      aShift = 1; aNum = 5'd8; tick(); aShift = 0;
      chk("t3c_win", 64'(aWin), 64'hBEEF);
      chk("t3c_fill", 64'(aFill), 64'd16);
      aValid = 1; aData = 16'h5A69; aShift = 1; aNum = 5'd8; #1;
      chk("t3d_ready", 64'(aReady), 64'd1);
      tick(); aValid = 0; aShift = 0;
      chk("t3d_win", 64'(aWin), 64'hEF5A);
      chk("t3d_fill", 64'(aFill), 64'd24);
      chk("t3d_cnt", 64'(aCnt), 64'd40);

      // T4 byte align
      aShift = 1; aNum = 5'd5; tick(); aShift = 0;
      chk("t4a_win", 64'(aWin), 64'hEB4D);
      chk("t4a_cnt", 64'(aCnt), 64'd45);
      aAlign = 1; tick(); aAlign = 0;
      chk("t4b_cnt", 64'(aCnt), 64'd48);
      chk("t4b_fill", 64'(aFill), 64'd16);
      chk("t4b_win", 64'(aWin), 64'h5A69);
      aAlign = 1; tick(); aAlign = 0;
      chk("t4c_cnt", 64'(aCnt), 64'd48);
      chk("t4c_fill", 64'(aFill), 64'd16);
      chk("t4c_err", 64'(aErr), 64'd0);
      aAlign = 1; aShift = 1; aNum = 5'd4; tick(); aAlign = 0; aShift = 0;
      chk("t4d_cnt", 64'(aCnt), 64'd52);
      chk("t4d_win", 64'(aWin), 64'hA690);

      // T5 illegal shift leaves state, sets sticky error
      aShift = 1; aNum = 5'd7; tick();
      chk("t5a_fill", 64'(aFill), 64'd5);
      chk("t5a_win", 64'(aWin), 64'h4800);
      aNum = 5'd6; tick(); aShift = 0;
      chk("t5b_fill", 64'(aFill), 64'd5);
      chk("t5b_win", 64'(aWin), 64'h4800);
      chk("t5b_cnt", 64'(aCnt), 64'd59);
      chk("t5b_err", 64'(aErr), 64'd1);
      aAlign = 1; tick(); aAlign = 0;
      chk("t5c_fill", 64'(aFill), 64'd0);
      chk("t5c_cnt", 64'(aCnt), 64'd64);
      chk("t5c_err", 64'(aErr), 64'd1);

      // T6 flush drops the same-cycle word and keeps the count
      aValid = 1; aData = 16'h1111; tick(); aValid = 0;
      chk("t6a_fill", 64'(aFill), 64'd16);
      aFlush = 1; aValid = 1; aData = 16'h2222; aShift = 1; aNum = 5'd4; #1;
      chk("t6b_ready", 64'(aReady), 64'd0);
      tick(); aFlush = 0; aValid = 0; aShift = 0;
      chk("t6b_fill", 64'(aFill), 64'd0);
      chk("t6b_win", 64'(aWin), 64'h0);
      chk("t6b_cnt", 64'(aCnt), 64'd64);

      // Enable low holds everything
      aValid = 1; aData = 16'hC0DE; tick(); aValid = 0;
      en = 0; aValid = 1; aData = 16'hFFFF; aShift = 1; aNum = 5'd4; aFlush = 1; #1;
      chk("en_ready", 64'(aReady), 64'd0);
      tick(); tick();
      en = 1; aValid = 0; aShift = 0; aFlush = 0;
      chk("en_fill", 64'(aFill), 64'd16);
      chk("en_win", 64'(aWin), 64'hC0DE);
      chk("en_cnt", 64'(aCnt), 64'd64);

      // Reset mid-stream
      rst = 1; tick();
      chk("mrst_fill", 64'(aFill), 64'd0);
      chk("mrst_win", 64'(aWin), 64'h0);
      chk("mrst_cnt", 64'(aCnt), 64'd0);
      chk("mrst_err", 64'(aErr), 64'd0);
      chk("mrst_ready", 64'(aReady), 64'd0);
      rst = 0;

      // Align distance larger than fill is an error
      aValid = 1; aData = 16'hF00F; tick(); aValid = 0;
      aShift = 1; aNum = 5'd3; tick(); aShift = 0;
      aFlush = 1; tick(); aFlush = 0;
      aValid = 1; aData = 16'h0FF0; tick(); aValid = 0;
      aShift = 1; aNum = 5'd14; tick(); aShift = 0;
      chk("aerr_fill0", 64'(aFill), 64'd2);
      chk("aerr_cnt0", 64'(aCnt), 64'd17);
      chk("aerr_err0", 64'(aErr), 64'd0);
      aAlign = 1; tick(); aAlign = 0;
      chk("aerr_fill", 64'(aFill), 64'd2);
      chk("aerr_cnt", 64'(aCnt), 64'd17);
      chk("aerr_err", 64'(aErr), 64'd1);
      rst = 1; tick(); rst = 0;

      // NumShift beyond WIN_W is illegal even with enough fill
      aValid = 1; aData = 16'hA5C3; tick();
      aData = 16'h1234; tick(); aValid = 0;
      aShift = 1; aNum = 5'd17; tick(); aShift = 0;
      chk("big_fill", 64'(aFill), 64'd32);
      chk("big_win", 64'(aWin), 64'hA5C3);
      chk("big_cnt", 64'(aCnt), 64'd0);
      chk("big_err", 64'(aErr), 64'd1);

      // Instance B: IN_W=8, WIN_W=32, 4-bit counter
      bValid = 1;
      bData = 8'hAB; tick();
      bData = 8'hCD; tick();
      bData = 8'hEF; tick();
      bData = 8'h12; tick();
      bValid = 0; #1;
      chk("b_fill", 64'(bFill), 64'd32);
      chk("b_win", 64'(bWin), 64'hABCDEF12);
      chk("b_winv", 64'(bWinV), 64'd1);
      chk("b_ready", 64'(bReady), 64'd1);
      bShift = 1; bNum = 6'd12; tick(); bShift = 0;
      chk("b_sh_win", 64'(bWin), 64'hDEF12000);
      chk("b_sh_fill", 64'(bFill), 64'd20);
      chk("b_sh_cnt", 64'(bCnt), 64'd12);
      bValid = 1; bData = 8'h34; bShift = 1; bNum = 6'd4; tick(); bValid = 0; bShift = 0;
      chk("b_mix_win", 64'(bWin), 64'hEF123400);
      chk("b_mix_fill", 64'(bFill), 64'd24);
      chk("b_wrap_cnt", 64'(bCnt), 64'd0);
      chk("b_err", 64'(bErr), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
